// File: rtl/ahb_dec_pkg.sv
// Shared encodings for the AHB-Lite decoder: transfer types, responses and
// the default-slave state enum.
package ahb_dec_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: produces the two-cycle AHB ERROR response for transfers
// that no slave claims, and records the first failing address plus a
// saturating error count.
//
// Handshake: a transfer is accepted on a rising edge where hready=1 and the
// address phase carries NONSEQ/SEQ; "unclaimed" marks that no slave matched.
module ahb_default_slave
    import ahb_dec_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        pwrup_rst_n,
    input  logic        hready,
    input  logic        unclaimed,
    input  logic [31:0] haddr,
    input  logic        err_clr,
    output logic [1:0]  state,
    output logic        ds_hready,
    output logic        ds_hresp,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic [7:0]  err_cnt
);

    ds_state_t state_q;
    ds_state_t state_d;
    logic      accept;

    // Every entry into DS_ERR1 is exactly one accepted unclaimed transfer.
    assign accept = hready & unclaimed;
    assign state  = state_q;

    // State register.
    always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
        if (!pwrup_rst_n) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the error response driven in each state.
    always_comb begin
        state_d   = state_q;
        ds_hready = 1'b1;
        ds_hresp  = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (accept) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = HRESP_ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                ds_hresp = HRESP_ERROR;
                state_d  = accept ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // Error capture; a clear in the same cycle as an error drops that error.
    always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
        if (!pwrup_rst_n) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
            err_cnt   <= 8'h0;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
            err_cnt   <= 8'h0;
        end else if (accept) begin
            if (!err_valid) begin
                err_addr <= haddr;
            end
            err_valid <= 1'b1;
            if (err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_decoder.sv
// AHB-Lite address decoder and response multiplexer with a built-in default
// slave for unmapped addresses.
//
// Handshake: the address phase on m_haddr/m_htrans is accepted on a rising
// edge with m_hready=1; the data phase then completes on the first later
// edge where m_hready=1. m_hready is also the HREADY_IN seen by all slaves.
module ahb_lite_decoder
    import ahb_dec_pkg::*;
#(
    parameter int          N_SLAVES = 2,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] SLV_BASE [N_SLAVES] = '{32'hFFDF_0000, 32'hFFFE_0000},
    parameter logic [31:0] SLV_MASK [N_SLAVES] = '{32'hFFFF_0000, 32'hFFFE_0000}
) (
    input  logic                       cpu_clk,
    input  logic                       pwrup_rst_n,
    input  logic [31:0]                m_haddr,
    input  logic [1:0]                 m_htrans,
    output logic                       m_hready,
    output logic                       m_hresp,
    output logic [DATA_W-1:0]          m_hrdata,
    output logic [N_SLAVES-1:0]        s_hsel,
    input  logic [N_SLAVES-1:0]        s_hreadyout,
    input  logic [N_SLAVES-1:0]        s_hresp,
    input  logic [N_SLAVES*DATA_W-1:0] s_hrdata,
    input  logic                       err_clr,
    output logic                       err_valid,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_cnt
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             is_xfer;
    logic             dph_act;
    logic             dph_def;
    logic [IDX_W-1:0] dph_idx;
    logic [1:0]       ds_state;
    logic             ds_busy;
    logic             ds_hready;
    logic             ds_hresp;

    assign is_xfer = (m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ);
    assign ds_busy = (ds_state != DS_IDLE);

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_haddr & SLV_MASK[i]) == SLV_BASE[i]) begin
                dec_hit = 1'b1;
                dec_idx = i[IDX_W-1:0];
            end
        end
    end

    // One-hot select, independent of the transfer type.
    always_comb begin
        s_hsel = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (dec_hit && (dec_idx == i[IDX_W-1:0])) begin
                s_hsel[i] = 1'b1;
            end
        end
    end

    // Data-phase bookkeeping, advanced only when the bus accepts an address.
    always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
        if (!pwrup_rst_n) begin
            dph_act <= 1'b0;
            dph_def <= 1'b0;
            dph_idx <= '0;
        end else if (m_hready) begin
            dph_act <= is_xfer & dec_hit;
            dph_def <= is_xfer & ~dec_hit;
            dph_idx <= dec_idx;
        end
    end

    // Response mux: default slave overrides, then the active slave, else idle OKAY.
    always_comb begin
        m_hready = 1'b1;
        m_hresp  = HRESP_OKAY;
        m_hrdata = '0;
        if (ds_busy || dph_def) begin
            m_hready = ds_hready;
            m_hresp  = ds_hresp;
        end else if (dph_act) begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (dph_idx == i[IDX_W-1:0]) begin
                    m_hready = s_hreadyout[i];
                    m_hresp  = s_hresp[i];
                    m_hrdata = s_hrdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    ahb_default_slave u_ds (
        .cpu_clk     (cpu_clk),
        .pwrup_rst_n (pwrup_rst_n),
        .hready      (m_hready),
        .unclaimed   (is_xfer & ~dec_hit),
        .haddr       (m_haddr),
        .err_clr     (err_clr),
        .state       (ds_state),
        .ds_hready   (ds_hready),
        .ds_hresp    (ds_hresp),
        .err_valid   (err_valid),
        .err_addr    (err_addr),
        .err_cnt     (err_cnt)
    );

endmodule

// File: tb/tb_ahb_lite_decoder.sv
// Directed bench for ahb_lite_decoder with default parameters.
module tb_ahb_lite_decoder;
    import ahb_dec_pkg::*;

    logic        cpu_clk;
    logic        pwrup_rst_n;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hready;
    logic        m_hresp;
    logic [31:0] m_hrdata;
    logic [1:0]  s_hsel;
    logic [1:0]  s_hreadyout;
    logic [1:0]  s_hresp;
    logic [63:0] s_hrdata;
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ahb_lite_decoder u_dut (
        .cpu_clk     (cpu_clk),
        .pwrup_rst_n (pwrup_rst_n),
        .m_haddr     (m_haddr),
        .m_htrans    (m_htrans),
        .m_hready    (m_hready),
        .m_hresp     (m_hresp),
        .m_hrdata    (m_hrdata),
        .s_hsel      (s_hsel),
        .s_hreadyout (s_hreadyout),
        .s_hresp     (s_hresp),
        .s_hrdata    (s_hrdata),
        .err_clr     (err_clr),
        .err_valid   (err_valid),
        .err_addr    (err_addr),
        .err_cnt     (err_cnt)
    );

    // Clock.
    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    initial begin
        pwrup_rst_n = 1'b0;
        m_haddr     = 32'hFFFE_0010;
        m_htrans    = HTRANS_IDLE;
        s_hreadyout = 2'b11;
        s_hresp     = 2'b00;
        s_hrdata    = 64'h0;
        err_clr     = 1'b0;
        #3;
        // Reset values and decode during reset.
        check("rst_hready", m_hready, 1);
        check("rst_hresp", m_hresp, 0);
        check("rst_hrdata", m_hrdata, 0);
        check("rst_hsel", s_hsel, 2'b10);
        check("rst_err_valid", err_valid, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_err_cnt", err_cnt, 0);
        m_haddr = 32'hFFDF_1234;
        #1;
        check("dec_slave0", s_hsel, 2'b01);
        m_haddr = 32'hFFFF_5678;
        #1;
        check("dec_slave1_upper", s_hsel, 2'b10);
        m_haddr = 32'hFFDE_0000;
        #1;
        check("dec_unmapped", s_hsel, 2'b00);
        next_cycle();
        next_cycle();
        pwrup_rst_n = 1'b1;

        // Slave1 read with two wait states.
        next_cycle();
        m_haddr  = 32'hFFFE_0010;
        m_htrans = HTRANS_NONSEQ;
        settle();
        check("rd1_hsel", s_hsel, 2'b10);
        check("rd1_addr_hready", m_hready, 1);
        next_cycle();
        m_htrans    = HTRANS_IDLE;
        m_haddr     = 32'h0;
        s_hreadyout = 2'b01;
        settle();
        check("rd1_wait1", m_hready, 0);
        next_cycle();
        settle();
        check("rd1_wait2", m_hready, 0);
        next_cycle();
        s_hreadyout      = 2'b11;
        s_hrdata[63:32]  = 32'hDEAD_BEEF;
        settle();
        check("rd1_hready", m_hready, 1);
        check("rd1_hrdata", m_hrdata, 32'hDEAD_BEEF);
        check("rd1_hresp", m_hresp, 0);
        next_cycle();
        settle();
        check("rd1_idle_hrdata", m_hrdata, 0);
        check("rd1_idle_hready", m_hready, 1);

        // Single unmapped transfer.
        m_haddr  = 32'h1000_0000;
        m_htrans = HTRANS_NONSEQ;
        s_hrdata = 64'h1111_2222_3333_4444;
        settle();
        check("err1_hsel", s_hsel, 2'b00);
        next_cycle();
        m_htrans = HTRANS_IDLE;
        m_haddr  = 32'h0;
        settle();
        check("err1_c1_hready", m_hready, 0);
        check("err1_c1_hresp", m_hresp, 1);
        check("err1_c1_hrdata", m_hrdata, 0);
        next_cycle();
        settle();
        check("err1_c2_hready", m_hready, 1);
        check("err1_c2_hresp", m_hresp, 1);
        check("err1_c2_hrdata", m_hrdata, 0);
        next_cycle();
        settle();
        check("err1_done_hready", m_hready, 1);
        check("err1_done_hresp", m_hresp, 0);
        check("err1_valid", err_valid, 1);
        check("err1_addr", err_addr, 32'h1000_0000);
        check("err1_cnt", err_cnt, 1);

        // Clear, then two back-to-back unmapped transfers.
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        settle();
        check("clr_valid", err_valid, 0);
        check("clr_addr", err_addr, 0);
        check("clr_cnt", err_cnt, 0);
        m_haddr  = 32'h1000_0000;
        m_htrans = HTRANS_NONSEQ;
        next_cycle();
        m_haddr = 32'h2000_0000;
        settle();
        check("b2b_a_c1_hready", m_hready, 0);
        check("b2b_a_c1_hresp", m_hresp, 1);
        next_cycle();
        settle();
        check("b2b_a_c2_hready", m_hready, 1);
        check("b2b_a_c2_hresp", m_hresp, 1);
        next_cycle();
        m_htrans = HTRANS_IDLE;
        m_haddr  = 32'h0;
        settle();
        check("b2b_b_c1_hready", m_hready, 0);
        check("b2b_b_c1_hresp", m_hresp, 1);
        next_cycle();
        settle();
        check("b2b_b_c2_hready", m_hready, 1);
        check("b2b_b_c2_hresp", m_hresp, 1);
        next_cycle();
        settle();
        check("b2b_done_hresp", m_hresp, 0);
        check("b2b_err_addr", err_addr, 32'h1000_0000);
        check("b2b_err_cnt", err_cnt, 2);

        // Pipelined slave0 read (3 wait states) followed by slave1 read.
        s_hrdata = {32'hB1B1_0000, 32'hA0A0_0004};
        m_haddr  = 32'hFFDF_0004;
        m_htrans = HTRANS_NONSEQ;
        settle();
        check("pipe_hsel0", s_hsel, 2'b01);
        next_cycle();
        m_haddr     = 32'hFFFE_0000;
        s_hreadyout = 2'b10;
        settle();
        check("pipe_stall1_hsel", s_hsel, 2'b10);
        check("pipe_stall1_hready", m_hready, 0);
        next_cycle();
        settle();
        check("pipe_stall2_hsel", s_hsel, 2'b10);
        check("pipe_stall2_hready", m_hready, 0);
        next_cycle();
        settle();
        check("pipe_stall3_hsel", s_hsel, 2'b10);
        check("pipe_stall3_hready", m_hready, 0);
        next_cycle();
        s_hreadyout = 2'b11;
        settle();
        check("pipe_s0_hready", m_hready, 1);
        check("pipe_s0_hrdata", m_hrdata, 32'hA0A0_0004);
        next_cycle();
        m_htrans = HTRANS_IDLE;
        m_haddr  = 32'h0;
        settle();
        check("pipe_s1_hready", m_hready, 1);
        check("pipe_s1_hrdata", m_hrdata, 32'hB1B1_0000);
        check("pipe_s1_hresp", m_hresp, 0);
        next_cycle();

        // Error coinciding with a clear is not recorded.
        m_haddr  = 32'h1000_0000;
        m_htrans = HTRANS_NONSEQ;
        err_clr  = 1'b1;
        next_cycle();
        err_clr  = 1'b0;
        m_htrans = HTRANS_IDLE;
        settle();
        check("clrerr_c1_hready", m_hready, 0);
        check("clrerr_valid", err_valid, 0);
        check("clrerr_cnt", err_cnt, 0);
        next_cycle();
        next_cycle();

        // 256 errors saturate the counter.
        for (int k = 0; k < 256; k++) begin
            m_haddr  = 32'h3000_0000 + k;
            m_htrans = HTRANS_NONSEQ;
            next_cycle();
            m_htrans = HTRANS_IDLE;
            if (k == 254) begin
                settle();
                check("sat_cnt_255", err_cnt, 8'hFF);
            end
            next_cycle();
        end
        settle();
        check("sat_cnt_256", err_cnt, 8'hFF);
        check("sat_addr", err_addr, 32'h3000_0000);
        check("sat_valid", err_valid, 1);
        next_cycle();

        // Reset asserted during DS_ERR1.
        m_haddr  = 32'h1000_0000;
        m_htrans = HTRANS_NONSEQ;
        next_cycle();
        m_htrans = HTRANS_IDLE;
        settle();
        check("rerr_pre_hready", m_hready, 0);
        pwrup_rst_n = 1'b0;
        #1;
        check("rerr_hready", m_hready, 1);
        check("rerr_hresp", m_hresp, 0);
        check("rerr_cnt", err_cnt, 0);
        next_cycle();
        pwrup_rst_n = 1'b1;
        settle();
        check("rerr_state", u_dut.ds_state, DS_IDLE);
        m_haddr  = 32'hFFDF_0000;
        m_htrans = HTRANS_NONSEQ;
        next_cycle();
        m_htrans = HTRANS_IDLE;
        settle();
        check("post_rst_hready", m_hready, 1);
        check("post_rst_hresp", m_hresp, 0);
        check("post_rst_hrdata", m_hrdata, 32'hA0A0_0004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_decoder.md
AHB_LITE_DECODER -- requirements
Module: ahb_lite_decoder

Interface
REQ-001 Parameter N_SLAVES, default 2, number of AHB-Lite slave ports (1..16).
REQ-002 Parameter DATA_W, default 32, read-data width.
REQ-003 Parameter SLV_BASE, default {32'hFFDF_0000, 32'hFFFE_0000}, per-slave base address, N_SLAVES x 32.
REQ-004 Parameter SLV_MASK, default {32'hFFFF_0000, 32'hFFFE_0000}, per-slave compare mask, N_SLAVES x 32.
REQ-005 cpu_clk  in  1  clock, all state on rising edge.
REQ-006 pwrup_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 m_haddr  in  32  master address-phase address.
REQ-008 m_htrans  in  2  master transfer type.
REQ-009 m_hready  out  1  HREADY to master, also broadcast to all slaves as HREADY_IN.
REQ-010 m_hresp  out  1  HRESP to master.
REQ-011 m_hrdata  out  DATA_W  HRDATA to master.
REQ-012 s_hsel  out  N_SLAVES  per-slave select.
REQ-013 s_hreadyout  in  N_SLAVES  per-slave HREADYOUT.
REQ-014 s_hresp  in  N_SLAVES  per-slave HRESP.
REQ-015 s_hrdata  in  N_SLAVES*DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W].
REQ-016 err_clr  in  1  synchronous clear of error capture.
REQ-017 err_valid  out  1  sticky: a default-slave error has occurred.
REQ-018 err_addr  out  32  address of the first unclaimed transfer since the last clear.
REQ-019 err_cnt  out  8  saturating count of default-slave errors.

Function
REQ-020 Address decode is combinational. Slave i matches when (m_haddr & SLV_MASK[i]) == SLV_BASE[i]. On overlap, the lowest index wins. s_hsel is one-hot or zero, independent of m_htrans.
REQ-021 Data-phase state is captured only when m_hready=1: dph_idx (matched index), dph_act (m_htrans[1]=1 and a slave matches), and dph_def (m_htrans[1]=1 and no slave matches).
REQ-022 When dph_act=1: m_hready, m_hresp and m_hrdata equal s_hreadyout, s_hresp and s_hrdata of slave dph_idx, with zero added latency.
REQ-023 When neither dph_act nor dph_def is set (IDLE/BUSY data phase): m_hready=1, m_hresp=0, m_hrdata=0.
REQ-024 The default slave FSM has three states: DS_IDLE, DS_ERR1, DS_ERR2.
- DS_IDLE -> DS_ERR1 when an unclaimed NONSEQ/SEQ transfer is accepted.
- DS_ERR1 drives m_hready=0, m_hresp=1.
- DS_ERR2 drives m_hready=1, m_hresp=1.
- DS_ERR1 -> DS_ERR2 unconditionally.
- DS_ERR2 -> DS_ERR1 if another unclaimed NONSEQ/SEQ is accepted in that cycle; otherwise -> DS_IDLE.
REQ-025 In DS_ERR1 and DS_ERR2, m_hrdata=0.
REQ-026 Slave outputs are ignored while the FSM is not in DS_IDLE.
REQ-027 A transfer to a real slave accepted in DS_ERR2 proceeds normally from the next cycle.
REQ-028 On DS_IDLE -> DS_ERR1:
- err_addr loads m_haddr only if err_valid=0.
- err_valid is set.
- err_cnt increments, saturating at 8'hFF.
REQ-029 When err_clr=1, err_valid, err_addr and err_cnt clear next cycle. err_clr wins over a simultaneous error, which is then not recorded.
REQ-030 An address phase presented while m_hready=0 is not accepted and does not change data-phase state.

Reset
REQ-031 On pwrup_rst_n=0, asynchronously: dph_act=0, dph_def=0, dph_idx=0, FSM=DS_IDLE, err_valid=0, err_addr=0, err_cnt=0.
REQ-032 During reset: m_hready=1, m_hresp=0, m_hrdata=0. s_hsel follows decode.
REQ-033 Reset mid-transfer abandons any pending data phase. The first transfer after release is an address phase.

Structure
REQ-034 A shared package ahb_dec_pkg holds the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), the HRESP encodings (OKAY, ERROR) and the FSM state enum.
REQ-035 A single sub-module ahb_default_slave implements the FSM and the error capture. Decode and mux stay in the top.

Verification
REQ-036 Default parameters: NONSEQ read to 32'hFFFE_0010, slave1 holds hreadyout=0 for 2 cycles and returns 32'hDEADBEEF. Required: m_hready low for 2 cycles, then m_hrdata=32'hDEADBEEF, m_hresp=0.
REQ-037 NONSEQ to unmapped 32'h1000_0000. Required: exactly one cycle of hready=0/hresp=1, then one cycle of hready=1/hresp=1; err_valid=1, err_addr=32'h1000_0000, err_cnt=1.
REQ-038 Back-to-back unclaimed at 32'h1000_0000 then 32'h2000_0000. Required: two complete two-cycle error responses; err_addr stays 32'h1000_0000; err_cnt=2.
REQ-039 Pipelined read slave0 @32'hFFDF_0004 followed by read slave1 @32'hFFFE_0000, slave0 stalling 3 cycles. Required: slave1 s_hsel is held during the stall, the slave1 data phase starts only after slave0 completes, and each returns its own data.
REQ-040 Error with err_clr asserted in the same cycle. Required: err_valid=0, err_cnt=0; 256 further errors leave err_cnt=8'hFF.
REQ-041 pwrup_rst_n asserted during DS_ERR1. Required: m_hready=1 and m_hresp=0 immediately; FSM is in DS_IDLE after release.
